// File: rtl/inst_fetch_router_if.sv
// Fetch-router bundle: jump/stall control, instruction-memory request/response, decode output.
// The master side is whoever drives control and memory responses; the router is the slave.
interface inst_fetch_router_if #(
   parameter int ADDR_W = 16,
   parameter int INST_W = 32
);
   logic              jumpEn;
   logic [ADDR_W-1:0] jumpTarget;
   logic              stallEn;
   logic              memReq;
   logic [ADDR_W-1:0] memAddr;
   logic              memRspValid;
   logic [INST_W-1:0] memInstIn;
   logic              instValid;
   logic [ADDR_W-1:0] pcOut;
   logic [INST_W-1:0] instOut;

   modport master (
      output jumpEn, jumpTarget, stallEn, memRspValid, memInstIn,
      input  memReq, memAddr, instValid, pcOut, instOut
   );

   modport slave (
      input  jumpEn, jumpTarget, stallEn, memRspValid, memInstIn,
      output memReq, memAddr, instValid, pcOut, instOut
   );
endinterface

// File: rtl/inst_fetch_router.sv
// Instruction fetch router: owns the fetch PC, keeps pipelined reads in flight, queues returned words.
// Optional INST_ROUTER_PERF_EN adds saturating bubble/flush counters.
module inst_fetch_router #(
   parameter int                 ADDR_W     = 16,
   parameter int                 INST_W     = 32,
   parameter int                 DEPTH      = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC   = 16'h0000,
   parameter logic [INST_W-1:0]  STALL_INST = 32'h00000013
) (
   input  logic               clk,
   input  logic               rst_n,
   inst_fetch_router_if.slave bus
`ifdef INST_ROUTER_PERF_EN
   ,
   output logic [15:0]        perfBubbles,
   output logic [15:0]        perfFlushes
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] q_addr_q [DEPTH];
   logic [INST_W-1:0] q_inst_q [DEPTH];

   logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     outst_q, outst_d;
   logic [CW-1:0]     drop_q, drop_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
   logic [ADDR_W-1:0] last_pc_q, last_pc_d;

   logic              rsp_acc, issue, push, pop, inst_valid;
   logic [CW:0]       credit;
   logic [ADDR_W-1:0] jump_pc;

   assign jump_pc    = bus.jumpTarget & ~ADDR_W'(3);
   assign rsp_acc    = bus.memRspValid && (outst_q != '0);
   assign credit     = {1'b0, count_q} + {1'b0, outst_q};
   // Gated by rst_n so the request line is quiet while reset is held asynchronously.
   assign issue      = rst_n && !bus.jumpEn && (credit < (CW+1)'(DEPTH));
   assign inst_valid = (count_q != '0) && !bus.jumpEn;
   assign pop        = inst_valid && !bus.stallEn;
   assign push       = rsp_acc && (drop_q == '0) && !bus.jumpEn;

   always_comb begin
      count_d    = count_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      last_pc_d  = inst_valid ? q_addr_q[rd_ptr_q] : last_pc_q;
      if (bus.jumpEn) begin
         // Every read still in flight after this edge belongs to the abandoned stream.
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         outst_d    = outst_q - CW'(rsp_acc);
         drop_d     = outst_q - CW'(rsp_acc);
         fetch_pc_d = jump_pc;
         rsp_pc_d   = jump_pc;
      end else begin
         count_d = count_q + CW'(push) - CW'(pop);
         outst_d = outst_q + CW'(issue) - CW'(rsp_acc);
         drop_d  = drop_q - CW'(rsp_acc && (drop_q != '0));
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            rsp_pc_d = rsp_pc_q + ADDR_W'(4);
         end
         if (pop)   rd_ptr_d   = rd_ptr_q + 1'b1;
         if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         last_pc_q  <= RESET_PC;
      end else begin
         count_q    <= count_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         last_pc_q  <= last_pc_d;
      end
   end

   // Queue storage carries no reset; the count alone says which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr_q[wr_ptr_q] <= rsp_pc_q;
         q_inst_q[wr_ptr_q] <= bus.memInstIn;
      end
   end

   assign bus.memReq    = issue;
   assign bus.memAddr   = fetch_pc_q;
   assign bus.instValid = inst_valid;
   assign bus.instOut   = inst_valid ? q_inst_q[rd_ptr_q] : STALL_INST;
   assign bus.pcOut     = inst_valid ? q_addr_q[rd_ptr_q] : last_pc_q;

`ifdef INST_ROUTER_PERF_EN
   logic [15:0] bubbles_q, flushes_q;
   logic        bubble;

   assign bubble = !inst_valid && !bus.stallEn;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubbles_q <= '0;
         flushes_q <= '0;
      end else begin
         if (bubble && (bubbles_q != 16'hFFFF))     bubbles_q <= bubbles_q + 16'd1;
         if (bus.jumpEn && (flushes_q != 16'hFFFF)) flushes_q <= flushes_q + 16'd1;
      end
   end

   assign perfBubbles = bubbles_q;
   assign perfFlushes = flushes_q;
`endif
endmodule

// File: tb/tb_inst_fetch_router.sv
// Directed bench for inst_fetch_router against a 1/2-cycle ROM returning {16'hA5A5, addr}.
// Build with INST_ROUTER_PERF_EN to also exercise the saturating counters.
module tb_inst_fetch_router;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   lat = 1;
   logic spur = 1'b0;

   always #5 clk = ~clk;

   inst_fetch_router_if #(.ADDR_W(16), .INST_W(32)) bus ();

`ifdef INST_ROUTER_PERF_EN
   logic [15:0] perf_bub, perf_fl;
   inst_fetch_router dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                          .perfBubbles(perf_bub), .perfFlushes(perf_fl));
`else
   inst_fetch_router dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   // ROM with selectable 1- or 2-cycle latency.
   logic        s1_v, s2_v;
   logic [15:0] s1_a, s2_a;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0; s2_v <= 1'b0; s1_a <= '0; s2_a <= '0;
      end else begin
         s1_v <= bus.memReq; s1_a <= bus.memAddr;
         s2_v <= s1_v;       s2_a <= s1_a;
      end
   end
   assign bus.memRspValid = ((lat == 2) ? s2_v : s1_v) | spur;
   assign bus.memInstIn   = {16'hA5A5, (lat == 2) ? s2_a : s1_a};

   typedef struct {
      logic        stall;
      logic        jump;
      logic [15:0] tgt;
      logic        spur;
      logic        req;
      logic [15:0] addr;
      logic        valid;
      logic        chk_pc;
      logic [15:0] pc;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic st, logic jp, logic [15:0] tg, logic sp, logic rq,
                               logic [15:0] ad, logic vl, logic cp, logic [15:0] p);
      vec_t v;
      v.stall = st; v.jump = jp; v.tgt = tg; v.spur = sp; v.req = rq;
      v.addr = ad; v.valid = vl; v.chk_pc = cp; v.pc = p;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [31:0] exp_inst;
      int          waited;
      bit          found;

      // cycle-by-cycle vectors starting at the first edge after reset release
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0000, 0,0,16'h0000)); // c0
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0004, 0,0,16'h0000));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0008, 1,1,16'h0000));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h000C, 1,1,16'h0004));
      vq.push_back(mk(1,0,16'h0000,0, 1,16'h0010, 1,1,16'h0008)); // stall x6
      vq.push_back(mk(1,0,16'h0000,0, 1,16'h0014, 1,1,16'h0008));
      vq.push_back(mk(1,0,16'h0000,0, 0,16'h0018, 1,1,16'h0008));
      vq.push_back(mk(1,0,16'h0000,1, 0,16'h0018, 1,1,16'h0008)); // spurious response
      vq.push_back(mk(1,0,16'h0000,0, 0,16'h0018, 1,1,16'h0008));
      vq.push_back(mk(1,0,16'h0000,0, 0,16'h0018, 1,1,16'h0008));
      vq.push_back(mk(0,0,16'h0000,0, 0,16'h0018, 1,1,16'h0008)); // release
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0018, 1,1,16'h000C));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h001C, 1,1,16'h0010));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0020, 1,1,16'h0014));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0024, 1,1,16'h0018));
      vq.push_back(mk(0,1,16'h0100,0, 0,16'h0028, 0,0,16'h0000)); // jump 0100
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0100, 0,0,16'h0000));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0104, 0,0,16'h0000));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0108, 1,1,16'h0100));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h010C, 1,1,16'h0104));
      vq.push_back(mk(0,1,16'h0102,0, 0,16'h0110, 0,0,16'h0000)); // jump 0102
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0100, 0,0,16'h0000));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0104, 0,0,16'h0000));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0108, 1,1,16'h0100));
      vq.push_back(mk(0,1,16'hFFFC,0, 0,16'h010C, 0,0,16'h0000)); // jump FFFC
      vq.push_back(mk(0,0,16'h0000,0, 1,16'hFFFC, 0,0,16'h0000));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0000, 0,0,16'h0000));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0004, 1,1,16'hFFFC));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0008, 1,1,16'h0000));
      vq.push_back(mk(1,1,16'h0200,0, 0,16'h000C, 0,0,16'h0000)); // jump + stall
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0200, 0,0,16'h0000));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0204, 0,0,16'h0000));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0208, 1,1,16'h0200));
      vq.push_back(mk(0,1,16'h0300,0, 0,16'h020C, 0,0,16'h0000)); // back-to-back jumps
      vq.push_back(mk(0,1,16'h0400,0, 0,16'h0300, 0,0,16'h0000));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0400, 0,0,16'h0000));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0404, 0,0,16'h0000));
      vq.push_back(mk(0,0,16'h0000,0, 1,16'h0408, 1,1,16'h0400));

      bus.jumpEn = 1'b0; bus.jumpTarget = '0; bus.stallEn = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_memReq", bus.memReq, 0);
      chk("reset_instValid", bus.instValid, 0);
      chk("reset_instOut", bus.instOut, 32'h00000013);
      chk("reset_pcOut", bus.pcOut, 16'h0000);
`ifdef INST_ROUTER_PERF_EN
      chk("reset_perfBubbles", perf_bub, 0);
      chk("reset_perfFlushes", perf_fl, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vq[i]) begin
         bus.stallEn = vq[i].stall; bus.jumpEn = vq[i].jump;
         bus.jumpTarget = vq[i].tgt; spur = vq[i].spur;
         #1;
         exp_inst = vq[i].valid ? {16'hA5A5, vq[i].pc} : 32'h00000013;
         chk($sformatf("c%0d_memReq", i), bus.memReq, vq[i].req);
         chk($sformatf("c%0d_memAddr", i), bus.memAddr, vq[i].addr);
         chk($sformatf("c%0d_instValid", i), bus.instValid, vq[i].valid);
         chk($sformatf("c%0d_instOut", i), bus.instOut, exp_inst);
         if (vq[i].chk_pc) chk($sformatf("c%0d_pcOut", i), bus.pcOut, vq[i].pc);
         $display("vec c%0d: req=%0b addr=%h valid=%0b pc=%h inst=%h", i,
                  bus.memReq, bus.memAddr, bus.instValid, bus.pcOut, bus.instOut);
         @(negedge clk);
      end
      bus.stallEn = 1'b0; bus.jumpEn = 1'b0; spur = 1'b0;

      // 2-cycle memory: jump with two reads in flight, one of which must be dropped
      rst_n = 1'b0; lat = 2;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      bus.jumpEn = 1'b1; bus.jumpTarget = 16'h0500;
      @(negedge clk);
      bus.jumpEn = 1'b0;
      found = 0; waited = 0;
      while (!found && waited < 20) begin
         #1;
         if (bus.instValid) found = 1;
         else begin @(negedge clk); waited++; end
      end
      chk("drop_found_valid", found, 1);
      chk("drop_first_pc", bus.pcOut, 16'h0500);
      chk("drop_first_inst", bus.instOut, 32'hA5A50500);
      $display("drop test: first pc=%h inst=%h after %0d cycles", bus.pcOut, bus.instOut, waited);
      @(negedge clk); #1;
      chk("drop_second_valid", bus.instValid, 1);
      chk("drop_second_pc", bus.pcOut, 16'h0504);

      // asynchronous reset between edges while streaming
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_instValid", bus.instValid, 0);
      chk("async_memReq", bus.memReq, 0);
      chk("async_instOut", bus.instOut, 32'h00000013);
      chk("async_pcOut", bus.pcOut, 16'h0000);
      $display("async reset: valid=%0b req=%0b inst=%h", bus.instValid, bus.memReq, bus.instOut);
      lat = 1;
`ifdef INST_ROUTER_PERF_EN
      chk("async_perfBubbles", perf_bub, 0);
      chk("async_perfFlushes", perf_fl, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.jumpEn = 1'b1; bus.jumpTarget = 16'h0000;
      repeat (10) @(negedge clk);
      #1;
      chk("perf_bubbles_10", perf_bub, 10);
      chk("perf_flushes_10", perf_fl, 10);
      repeat (70000) @(negedge clk);
      #1;
      chk("perf_bubbles_sat", perf_bub, 16'hFFFF);
      chk("perf_flushes_sat", perf_fl, 16'hFFFF);
      $display("perf: bubbles=%h flushes=%h", perf_bub, perf_fl);
      bus.jumpEn = 1'b0;
`endif
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
